// File: rtl/tag_collision_tracker.sv
// Purpose: per-lane outstanding A-tag table; flags B requests that reuse a held tag.
// Latency: one cycle from the B strobe to valid/coll_any/sticky/count/first-capture.
// Backpressure: none; this is a passive monitor beside the tag paths.
module tag_collision_tracker #(
  parameter int LANES      = 8,
  parameter int TAG_W      = 16,
  parameter int CROSS_LANE = 0,
  parameter int CNT_W      = 8,
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       vlda,
  input  logic [LANES*TAG_W-1:0] taga,
  input  logic [LANES-1:0]       rel_a,
  input  logic [LANES-1:0]       vldb,
  input  logic [LANES*TAG_W-1:0] tagb,
  input  logic                   clr,
  output logic [LANES-1:0]       valid,
  output logic                   coll_any,
  output logic [LANES-1:0]       coll_sticky,
  output logic [CNT_W-1:0]       coll_cnt,
  output logic                   first_vld,
  output logic [LW-1:0]          first_lane,
  output logic [TAG_W-1:0]       first_tag
);

  localparam int PCW = $clog2(LANES + 1);
  localparam int SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LANES-1:0] held;
  logic [TAG_W-1:0] held_tag [LANES];

  logic [LANES-1:0] hit;
  logic [PCW-1:0]   hit_cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [SW-1:0]    cnt_sum;
  logic [CNT_W-1:0] cnt_next;
  logic [LW-1:0]    hit_lane;
  logic [TAG_W-1:0] hit_tag;
  logic             first_keep;

  // Entry table: a load always wins over a release on the same lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
      for (int i = 0; i < LANES; i++) held_tag[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (vlda[i]) begin
          held[i]     <= 1'b1;
          held_tag[i] <= taga[i*TAG_W +: TAG_W];
        end else if (rel_a[i]) begin
          held[i] <= 1'b0;
        end
      end
    end
  end

  // Hit detection from registered table only (no same-cycle load bypass).
  always_comb begin
    hit = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (vldb[i] && held[j] && (CROSS_LANE != 0 || i == j) &&
            held_tag[j] == tagb[i*TAG_W +: TAG_W])
          hit[i] = 1'b1;
      end
    end
  end

  // Popcount, saturating count, and lowest-lane hit selection.
  always_comb begin
    hit_cnt  = '0;
    hit_lane = '0;
    hit_tag  = '0;
    for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + PCW'(hit[i]);
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_lane = LW'(i);
        hit_tag  = tagb[i*TAG_W +: TAG_W];
      end
    end
    cnt_base   = clr ? '0 : coll_cnt;
    cnt_sum    = SW'(cnt_base) + SW'(hit_cnt);
    cnt_next   = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    first_keep = first_vld && !clr;
  end

  // Registered observation outputs; clr clears first, then this cycle's hits accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '1;
      coll_any    <= 1'b0;
      coll_sticky <= '0;
      coll_cnt    <= '0;
      first_vld   <= 1'b0;
      first_lane  <= '0;
      first_tag   <= '0;
    end else begin
      valid       <= ~hit;
      coll_any    <= |hit;
      coll_sticky <= (clr ? '0 : coll_sticky) | hit;
      coll_cnt    <= cnt_next;
      if (!first_keep && |hit) begin
        first_vld  <= 1'b1;
        first_lane <= hit_lane;
        first_tag  <= hit_tag;
      end else if (clr) begin
        first_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tag_collision_tracker.sv
// Directed bench: two trackers share stimulus, one same-lane (8-bit count), one cross-lane (2-bit count).
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Expected values are hand-derived from the tag table contents each test builds up.
module tb_tag_collision_tracker;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   vlda, rel_a, vldb;
  logic [127:0] taga, tagb;
  logic         clr;

  logic [7:0]  valid0, sticky0, valid1, sticky1;
  logic        any0, fv0, any1, fv1;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
  logic [2:0]  fl0, fl1;
  logic [15:0] ft0, ft1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tag_collision_tracker #(.LANES(8), .TAG_W(16), .CROSS_LANE(0), .CNT_W(8)) d0 (
    .clk(clk), .rst(rst), .vlda(vlda), .taga(taga), .rel_a(rel_a), .vldb(vldb),
    .tagb(tagb), .clr(clr), .valid(valid0), .coll_any(any0), .coll_sticky(sticky0),
    .coll_cnt(cnt0), .first_vld(fv0), .first_lane(fl0), .first_tag(ft0));

  tag_collision_tracker #(.LANES(8), .TAG_W(16), .CROSS_LANE(1), .CNT_W(2)) d1 (
    .clk(clk), .rst(rst), .vlda(vlda), .taga(taga), .rel_a(rel_a), .vldb(vldb),
    .tagb(tagb), .clr(clr), .valid(valid1), .coll_any(any1), .coll_sticky(sticky1),
    .coll_cnt(cnt1), .first_vld(fv1), .first_lane(fl1), .first_tag(ft1));

  task automatic idle_inputs();
    vlda = '0; rel_a = '0; vldb = '0; taga = '0; tagb = '0; clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (valid0 !== 8'hFF) begin n_fail++; $display("FAIL reset_valid0 got %h want ff", valid0); end
    n_cmp++; if (any0 !== 1'b0) begin n_fail++; $display("FAIL reset_any0 got %b want 0", any0); end
    n_cmp++; if (cnt0 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
    n_cmp++; if (fv0 !== 1'b0) begin n_fail++; $display("FAIL reset_fv0 got %b want 0", fv0); end
    n_cmp++; if (sticky0 !== 8'h00) begin n_fail++; $display("FAIL reset_sticky0 got %h want 00", sticky0); end
    n_cmp++; if (fl0 !== 3'd0 || ft0 !== 16'h0) begin n_fail++; $display("FAIL reset_first0 got %0d/%h want 0/0000", fl0, ft0); end
    n_cmp++; if (valid1 !== 8'hFF || cnt1 !== 2'd0) begin n_fail++; $display("FAIL reset_d1 got %h/%0d want ff/0", valid1, cnt1); end
  endtask

  task automatic test_basic_hit();
    idle_inputs();
    vlda[2] = 1'b1; taga[2*16 +: 16] = 16'hBEEF;
    tick();
    idle_inputs();
    vldb[2] = 1'b1; tagb[2*16 +: 16] = 16'hBEEF;
    tick();
    n_cmp++; if (valid0 !== 8'hFB) begin n_fail++; $display("FAIL basic_valid got %h want fb", valid0); end
    n_cmp++; if (any0 !== 1'b1) begin n_fail++; $display("FAIL basic_any got %b want 1", any0); end
    n_cmp++; if (sticky0 !== 8'h04) begin n_fail++; $display("FAIL basic_sticky got %h want 04", sticky0); end
    n_cmp++; if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL basic_cnt got %0d want 1", cnt0); end
    n_cmp++; if (fv0 !== 1'b1 || fl0 !== 3'd2 || ft0 !== 16'hBEEF) begin n_fail++; $display("FAIL basic_first got %b/%0d/%h want 1/2/beef", fv0, fl0, ft0); end
    idle_inputs();
    tick();
    n_cmp++; if (valid0 !== 8'hFF || any0 !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %h/%b want ff/0", valid0, any0); end
    n_cmp++; if (sticky0 !== 8'h04 || cnt0 !== 8'd1 || fl0 !== 3'd2) begin n_fail++; $display("FAIL idle_hold got %h/%0d/%0d want 04/1/2", sticky0, cnt0, fl0); end
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    vlda[3] = 1'b1; taga[3*16 +: 16] = 16'h0011;
    vldb[3] = 1'b1; tagb[3*16 +: 16] = 16'h0011;
    tick();
    n_cmp++; if (valid0 !== 8'hFF) begin n_fail++; $display("FAIL nobypass_valid0 got %h want ff", valid0); end
    n_cmp++; if (valid1 !== 8'hFF) begin n_fail++; $display("FAIL nobypass_valid1 got %h want ff", valid1); end
    vlda = '0;
    tick();
    n_cmp++; if (valid0 !== 8'hF7 || any0 !== 1'b1) begin n_fail++; $display("FAIL repeat_hit got %h/%b want f7/1", valid0, any0); end
    n_cmp++; if (sticky0 !== 8'h0C || cnt0 !== 8'd2) begin n_fail++; $display("FAIL repeat_acc got %h/%0d want 0c/2", sticky0, cnt0); end
    n_cmp++; if (fl0 !== 3'd2 || ft0 !== 16'hBEEF) begin n_fail++; $display("FAIL first_hold got %0d/%h want 2/beef", fl0, ft0); end
  endtask

  task automatic test_cross_lane();
    idle_inputs();
    vldb[5] = 1'b1; tagb[5*16 +: 16] = 16'h0011;
    tick();
    n_cmp++; if (valid0 !== 8'hFF) begin n_fail++; $display("FAIL same_lane_only got %h want ff", valid0); end
    n_cmp++; if (valid1 !== 8'hDF || any1 !== 1'b1) begin n_fail++; $display("FAIL cross_lane got %h/%b want df/1", valid1, any1); end
    n_cmp++; if (cnt1 !== 2'd3) begin n_fail++; $display("FAIL cross_cnt got %0d want 3", cnt1); end
    n_cmp++; if (cnt0 !== 8'd2) begin n_fail++; $display("FAIL cross_cnt0 got %0d want 2", cnt0); end
  endtask

  task automatic test_release();
    idle_inputs();
    vlda[1] = 1'b1; taga[1*16 +: 16] = 16'h1234;
    tick();
    idle_inputs();
    rel_a[1] = 1'b1; vldb[1] = 1'b1; tagb[1*16 +: 16] = 16'h1234;
    tick();
    n_cmp++; if (valid0 !== 8'hFD) begin n_fail++; $display("FAIL rel_same_cycle got %h want fd", valid0); end
    rel_a = '0;
    tick();
    n_cmp++; if (valid0 !== 8'hFF) begin n_fail++; $display("FAIL rel_after got %h want ff", valid0); end
    n_cmp++; if (valid1 !== 8'hFF) begin n_fail++; $display("FAIL rel_after1 got %h want ff", valid1); end
  endtask

  task automatic test_saturation();
    rst = 1'b1; idle_inputs();
    tick();
    rst = 1'b0;
    vlda = 8'hFF;
    for (int i = 0; i < 8; i++) taga[i*16 +: 16] = 16'h0007;
    tick();
    idle_inputs();
    vldb = 8'hFF;
    for (int i = 0; i < 8; i++) tagb[i*16 +: 16] = 16'h0007;
    tick();
    n_cmp++; if (valid1 !== 8'h00 || sticky1 !== 8'hFF) begin n_fail++; $display("FAIL multi_valid1 got %h/%h want 00/ff", valid1, sticky1); end
    n_cmp++; if (cnt1 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt1 got %0d want 3", cnt1); end
    n_cmp++; if (fv1 !== 1'b1 || fl1 !== 3'd0 || ft1 !== 16'h0007) begin n_fail++; $display("FAIL multi_first1 got %b/%0d/%h want 1/0/0007", fv1, fl1, ft1); end
    n_cmp++; if (valid0 !== 8'h00 || cnt0 !== 8'd8) begin n_fail++; $display("FAIL multi_d0 got %h/%0d want 00/8", valid0, cnt0); end
    tick();
    n_cmp++; if (cnt1 !== 2'd3) begin n_fail++; $display("FAIL sat_hold got %0d want 3", cnt1); end
    n_cmp++; if (cnt0 !== 8'd16) begin n_fail++; $display("FAIL multi_acc got %0d want 16", cnt0); end
  endtask

  task automatic test_clr();
    idle_inputs();
    clr = 1'b1; vldb[6] = 1'b1; tagb[6*16 +: 16] = 16'h0007;
    tick();
    n_cmp++; if (sticky0 !== 8'h40 || cnt0 !== 8'd1) begin n_fail++; $display("FAIL clr_hit_acc got %h/%0d want 40/1", sticky0, cnt0); end
    n_cmp++; if (fv0 !== 1'b1 || fl0 !== 3'd6) begin n_fail++; $display("FAIL clr_hit_first got %b/%0d want 1/6", fv0, fl0); end
    n_cmp++; if (sticky1 !== 8'h40 || cnt1 !== 2'd1 || fl1 !== 3'd6) begin n_fail++; $display("FAIL clr_hit_d1 got %h/%0d/%0d want 40/1/6", sticky1, cnt1, fl1); end
    n_cmp++; if (valid0 !== 8'hBF) begin n_fail++; $display("FAIL clr_valid got %h want bf", valid0); end
    idle_inputs();
    clr = 1'b1;
    tick();
    n_cmp++; if (fv0 !== 1'b0 || sticky0 !== 8'h00 || cnt0 !== 8'd0) begin n_fail++; $display("FAIL clr_only got %b/%h/%0d want 0/00/0", fv0, sticky0, cnt0); end
    n_cmp++; if (fl0 !== 3'd6 || ft0 !== 16'h0007) begin n_fail++; $display("FAIL clr_first_hold got %0d/%h want 6/0007", fl0, ft0); end
    n_cmp++; if (valid0 !== 8'hFF) begin n_fail++; $display("FAIL clr_valid_idle got %h want ff", valid0); end
    idle_inputs();
    vldb[6] = 1'b1; tagb[6*16 +: 16] = 16'h0007;
    tick();
    n_cmp++; if (valid0 !== 8'hBF || cnt0 !== 8'd1) begin n_fail++; $display("FAIL table_survives_clr got %h/%0d want bf/1", valid0, cnt0); end
  endtask

  task automatic test_rst_mid();
    idle_inputs();
    rst = 1'b1;
    vlda[4] = 1'b1; taga[4*16 +: 16] = 16'h9999;
    vldb[6] = 1'b1; tagb[6*16 +: 16] = 16'h0007;
    tick();
    rst = 1'b0; idle_inputs();
    n_cmp++; if (valid0 !== 8'hFF || any0 !== 1'b0 || sticky0 !== 8'h00 || cnt0 !== 8'd0) begin n_fail++; $display("FAIL rst_mid_out got %h/%b/%h/%0d want ff/0/00/0", valid0, any0, sticky0, cnt0); end
    n_cmp++; if (fv0 !== 1'b0 || fl0 !== 3'd0 || ft0 !== 16'h0) begin n_fail++; $display("FAIL rst_mid_first got %b/%0d/%h want 0/0/0000", fv0, fl0, ft0); end
    vldb[6] = 1'b1; tagb[6*16 +: 16] = 16'h0007;
    vldb[4] = 1'b1; tagb[4*16 +: 16] = 16'h9999;
    tick();
    n_cmp++; if (valid0 !== 8'hFF || valid1 !== 8'hFF) begin n_fail++; $display("FAIL rst_mid_table got %h/%h want ff/ff", valid0, valid1); end
    n_cmp++; if (cnt1 !== 2'd0 || fv1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_d1 got %0d/%b want 0/0", cnt1, fv1); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_hit();
    test_same_cycle();
    test_cross_lane();
    test_release();
    test_saturation();
    test_clr();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
